fp16_acc_seq: RTL

FP16_ACC_SEQ -- requirements
Module: fp16_acc_seq

---
 rtl/fp16_pkg.sv | 29 ++
 rtl/fp16_unpack.sv | 18 +
 rtl/fp16_acc_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared field widths, FP16 constants and FSM state encoding for the
// sequential FP16 accumulator.
package fp16_pkg;

    localparam int FP16_W    = 16;
    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int FP16_BIAS = 15;

    // Internal exponent carries one extra bit so an increment past 31 is visible.
    localparam int EXPI_W = EXP_W + 1;
    // Mantissa: carry bit, hidden bit, fraction.
    localparam int MAN_W  = FRAC_W + 2;

    localparam logic [FP16_W-1:0] FP16_INF     = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_MAX_FIN = 16'h7BFF;

    localparam logic [EXPI_W-1:0] EXP_INF  = EXPI_W'(2 * FP16_BIAS + 1);
    localparam logic [EXPI_W-1:0] EXP_MAXN = EXP_INF - 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack: splits an FP16 word into sign, widened exponent and a mantissa
// with explicit hidden bit; only the all-zero word gets a clear hidden bit.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] data,
    output logic              sign,
    output logic [EXPI_W-1:0] expo,
    output logic [MAN_W-1:0]  man
);

    always_comb begin
        sign = data[FP16_W-1];
        expo = {1'b0, data[FP16_W-2 -: EXP_W]};
        man  = {1'b0, (data != '0), data[FRAC_W-1:0]};
    end

endmodule

// File: rtl/fp16_acc_seq.sv
// fp16_acc_seq: multi-cycle FP16 accumulator (align / add / normalize, truncating).
// Define FP16_ACC_SAT_EN to saturate to the largest finite value on overflow
// instead of producing a signed infinity.
module fp16_acc_seq
    import fp16_pkg::*;
#(
    parameter int MAX_TERMS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] out_data,
    output logic              busy,
    output logic [7:0]        term_cnt
);

    localparam logic [7:0] MAX_CNT = MAX_TERMS[7:0];

    state_t            state;
    logic              run;
    logic              last_flag;

    logic              acc_sign;
    logic [EXPI_W-1:0] acc_exp;
    logic [MAN_W-1:0]  acc_man;
    logic              t_sign;
    logic [EXPI_W-1:0] t_exp;
    logic [MAN_W-1:0]  t_man;

    logic              u_sign;
    logic [EXPI_W-1:0] u_exp;
    logic [MAN_W-1:0]  u_man;

    logic              acc_big;
    logic [EXPI_W-1:0] exp_diff;
    logic              sum_sign;
    logic [MAN_W-1:0]  sum_man;

    logic              n_sign;
    logic [EXPI_W-1:0] n_exp;
    logic [MAN_W-1:0]  n_man;
    logic              n_done;
    logic [FP16_W-1:0] ovf;
    logic [FP16_W-1:0] n_word;

    function automatic logic [FP16_W-1:0] ovf_word(input logic sign);
`ifdef FP16_ACC_SAT_EN
        return {sign, FP16_MAX_FIN[FP16_W-2:0]};
`else
        return {sign, FP16_INF[FP16_W-2:0]};
`endif
    endfunction

    fp16_unpack u_unpack (
        .data (in_data),
        .sign (u_sign),
        .expo (u_exp),
        .man  (u_man)
    );

    assign in_ready  = run && (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        acc_big  = (acc_exp > t_exp);
        exp_diff = acc_big ? (acc_exp - t_exp) : (t_exp - acc_exp);
    end

    // Mixed signs: larger magnitude minus smaller; a tie leaves +0.
    always_comb begin
        sum_sign = 1'b0;
        sum_man  = '0;
        if (acc_sign == t_sign) begin
            sum_sign = acc_sign;
            sum_man  = acc_man + t_man;
        end else if (acc_man > t_man) begin
            sum_sign = acc_sign;
            sum_man  = acc_man - t_man;
        end else if (t_man > acc_man) begin
            sum_sign = t_sign;
            sum_man  = t_man - acc_man;
        end
    end

    // One normalization step per cycle; n_done marks the final step.
    always_comb begin
        ovf    = ovf_word(acc_sign);
        n_sign = acc_sign;
        n_exp  = acc_exp;
        n_man  = acc_man;
        n_done = 1'b1;
        if (acc_man == '0) begin
            n_sign = 1'b0;
            n_exp  = '0;
        end else if (acc_man[MAN_W-1]) begin
            if (acc_exp >= EXP_MAXN) begin
                n_sign = ovf[FP16_W-1];
                n_exp  = {1'b0, ovf[FP16_W-2 -: EXP_W]};
                n_man  = {2'b01, ovf[FRAC_W-1:0]};
            end else begin
                n_man = acc_man >> 1;
                n_exp = acc_exp + 1'b1;
            end
        end else if (acc_man[MAN_W-2]) begin
            if (acc_exp == '0) begin
                n_sign = 1'b0;
                n_man  = '0;
            end else if (acc_exp >= EXP_INF) begin
                n_sign = ovf[FP16_W-1];
                n_exp  = {1'b0, ovf[FP16_W-2 -: EXP_W]};
                n_man  = {2'b01, ovf[FRAC_W-1:0]};
            end
        end else if (acc_exp <= EXPI_W'(1)) begin
            n_sign = 1'b0;
            n_exp  = '0;
            n_man  = '0;
        end else begin
            n_man  = acc_man << 1;
            n_exp  = acc_exp - 1'b1;
            n_done = 1'b0;
        end
        n_word = {n_sign, n_exp[EXP_W-1:0], n_man[FRAC_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            last_flag <= 1'b0;
            term_cnt  <= '0;
            acc_sign  <= 1'b0;
            acc_exp   <= '0;
            acc_man   <= '0;
            t_sign    <= 1'b0;
            t_exp     <= '0;
            t_man     <= '0;
            out_data  <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        term_cnt  <= term_cnt + 8'd1;
                        last_flag <= in_last;
                        // An empty accumulator takes the term as-is.
                        if (acc_man == '0) begin
                            acc_sign <= u_sign;
                            acc_exp  <= u_exp;
                            acc_man  <= u_man;
                            state    <= ST_NORM;
                        end else begin
                            t_sign <= u_sign;
                            t_exp  <= u_exp;
                            t_man  <= u_man;
                            state  <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (exp_diff == '0) begin
                        state <= ST_ADD;
                    end else if (exp_diff >= EXPI_W'(12)) begin
                        if (acc_big) begin
                            t_man <= '0;
                            t_exp <= acc_exp;
                        end else begin
                            acc_man <= '0;
                            acc_exp <= t_exp;
                        end
                        state <= ST_ADD;
                    end else begin
                        if (acc_big) begin
                            t_man <= t_man >> 1;
                            t_exp <= t_exp + 1'b1;
                        end else begin
                            acc_man <= acc_man >> 1;
                            acc_exp <= acc_exp + 1'b1;
                        end
                        if (exp_diff == EXPI_W'(1)) state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    acc_sign <= sum_sign;
                    acc_man  <= sum_man;
                    state    <= ST_NORM;
                end
                ST_NORM: begin
                    acc_sign <= n_sign;
                    acc_exp  <= n_exp;
                    acc_man  <= n_man;
                    if (n_done) begin
                        if (last_flag || term_cnt == MAX_CNT) begin
                            out_data <= n_word;
                            state    <= ST_OUT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc_sign  <= 1'b0;
                        acc_exp   <= '0;
                        acc_man   <= '0;
                        term_cnt  <= '0;
                        last_flag <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
